// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD write path: word format and serializer states.
package lcd_pkg;

    // Upstream word: {dc, byte}
    localparam int unsigned LCD_WORD_W = 9;

    // D/C line encoding
    localparam logic LCD_DC_CMD  = 1'b0;
    localparam logic LCD_DC_DATA = 1'b1;

    // Serializer control states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2,
        GAP   = 2'd3
    } spi_state_t;

endpackage : lcd_pkg

// File: rtl/lcd_spi_tx.sv
// SPI mode-0 serializer for a 4-wire LCD bus with a one-word holding buffer.
// Words are {dc, byte}; the byte is shifted MSB first and wr_done pulses as CS rises.
module lcd_spi_tx
    import lcd_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic                  sys_clk_50MHz,
    input  logic                  sys_rst,
    input  logic [LCD_WORD_W-1:0] data,
    input  logic                  en_write,
    output logic                  lcd_cs_n,
    output logic                  lcd_sclk,
    output logic                  lcd_mosi,
    output logic                  lcd_dc,
    output logic                  busy,
    output logic                  wr_done,
    output logic                  ovf
);

    localparam int unsigned       PH_W    = $clog2(CLK_DIV) + 1;
    localparam logic [PH_W-1:0]   PH_LAST = PH_W'(CLK_DIV - 1);

    spi_state_t            state_q, state_d;
    logic [PH_W-1:0]       phase_q, phase_d;
    logic [2:0]            bit_q, bit_d;
    logic [7:0]            sr_q, sr_d;
    logic [LCD_WORD_W-1:0] buf_q, buf_d;
    logic                  buf_vld_q, buf_vld_d;
    logic                  cs_n_q, cs_n_d;
    logic                  sclk_q, sclk_d;
    logic                  mosi_q, mosi_d;
    logic                  dc_q, dc_d;
    logic                  busy_q, busy_d;
    logic                  wr_done_q, wr_done_d;
    logic                  ovf_q, ovf_d;

    logic                  phase_last;
    logic                  pop;
    logic                  start;
    logic [LCD_WORD_W-1:0] start_word;

    assign phase_last = (phase_q == PH_LAST);

    // State and output registers with synchronous reset
    always_ff @(posedge sys_clk_50MHz) begin
        if (sys_rst) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            bit_q     <= '0;
            sr_q      <= '0;
            buf_q     <= '0;
            buf_vld_q <= 1'b0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            dc_q      <= 1'b0;
            busy_q    <= 1'b0;
            wr_done_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            bit_q     <= bit_d;
            sr_q      <= sr_d;
            buf_q     <= buf_d;
            buf_vld_q <= buf_vld_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            dc_q      <= dc_d;
            busy_q    <= busy_d;
            wr_done_q <= wr_done_d;
            ovf_q     <= ovf_d;
        end
    end

    // Next-state logic: buffer management, SCLK phase sequencing and word start
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        bit_d      = bit_q;
        sr_d       = sr_q;
        buf_d      = buf_q;
        buf_vld_d  = buf_vld_q;
        cs_n_d     = cs_n_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        dc_d       = dc_q;
        wr_done_d  = 1'b0;
        ovf_d      = ovf_q;

        // A buffered word is launched straight out of the last GAP cycle so the
        // bus sees exactly CLK_DIV cycles of CS high between back-to-back words.
        pop        = buf_vld_q && ((state_q == IDLE) || ((state_q == GAP) && phase_last));
        start      = pop || ((state_q == IDLE) && en_write);
        start_word = pop ? buf_q : data;

        if (pop) begin
            buf_vld_d = en_write;
            if (en_write) begin
                buf_d = data;
            end
        end else if (en_write && (state_q != IDLE)) begin
            if (buf_vld_q) begin
                ovf_d = 1'b1;
            end else begin
                buf_d     = data;
                buf_vld_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
            end
            SHIFT: begin
                phase_d = phase_q + PH_W'(1);
                if (phase_last) begin
                    phase_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == 3'd0) begin
                            state_d = HOLD;
                        end else begin
                            bit_d  = bit_q - 3'd1;
                            sr_d   = {sr_q[6:0], 1'b0};
                            mosi_d = sr_q[6];
                        end
                    end
                end
            end
            HOLD: begin
                phase_d = phase_q + PH_W'(1);
                if (phase_last) begin
                    phase_d   = '0;
                    state_d   = GAP;
                    cs_n_d    = 1'b1;
                    wr_done_d = 1'b1;
                end
            end
            GAP: begin
                phase_d = phase_q + PH_W'(1);
                if (phase_last) begin
                    phase_d = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (start) begin
            state_d = SHIFT;
            phase_d = '0;
            bit_d   = 3'd7;
            sr_d    = start_word[7:0];
            dc_d    = start_word[8];
            mosi_d  = start_word[7];
            cs_n_d  = 1'b0;
            sclk_d  = 1'b0;
        end

        busy_d = (state_d != IDLE) || buf_vld_d;
    end

    assign lcd_cs_n = cs_n_q;
    assign lcd_sclk = sclk_q;
    assign lcd_mosi = mosi_q;
    assign lcd_dc   = dc_q;
    assign busy     = busy_q;
    assign wr_done  = wr_done_q;
    assign ovf      = ovf_q;

endmodule : lcd_spi_tx

// File: tb/tb_lcd_spi_tx.sv
// Scoreboard bench for lcd_spi_tx: a word-level schedule model predicts which
// strobes are sent and when; a bus monitor decodes SPI frames and compares.
module tb_lcd_spi_tx;
    import lcd_pkg::*;

    localparam int D = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [8:0] data = '0;
    logic       en = 1'b0;
    logic       cs_n, sclk, mosi, dc, busy, wr_done, ovf;

    logic [8:0] data1 = '0;
    logic       en1 = 1'b0;
    logic       cs1_n, sclk1, mosi1, dc1, busy1, wd1, ovf1;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int          cyc = 0;
    int          n_done = 0;

    typedef struct {
        logic [8:0] w;
        int         start;
    } exp_t;
    exp_t q[$];

    // Word-level model: end-of-gap time of the active word and the buffer slot
    int         act_end = -1000;
    bit         buf_v = 1'b0;
    int         buf_start = 0;
    bit         ovf_m = 1'b0;

    lcd_spi_tx #(.CLK_DIV(D)) dut (
        .sys_clk_50MHz(clk), .sys_rst(rst), .data(data), .en_write(en),
        .lcd_cs_n(cs_n), .lcd_sclk(sclk), .lcd_mosi(mosi), .lcd_dc(dc),
        .busy(busy), .wr_done(wr_done), .ovf(ovf)
    );

    lcd_spi_tx #(.CLK_DIV(1)) dut1 (
        .sys_clk_50MHz(clk), .sys_rst(rst), .data(data1), .en_write(en1),
        .lcd_cs_n(cs1_n), .lcd_sclk(sclk1), .lcd_mosi(mosi1), .lcd_dc(dc1),
        .busy(busy1), .wr_done(wd1), .ovf(ovf1)
    );

    // 100 MHz bench clock
    always #5 clk = ~clk;

    // Edge index: at a negedge, cyc equals the index of the preceding posedge
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model a strobe sampled at edge e
    task automatic model_strobe(input int e, input logic [8:0] w);
        exp_t x;
        if (buf_v && buf_start <= e) begin
            act_end = buf_start + 18 * D;
            buf_v   = 1'b0;
        end
        if (e > act_end) begin
            x.w = w; x.start = e;
            q.push_back(x);
            act_end = e + 18 * D;
        end else if (buf_v) begin
            ovf_m = 1'b1;
        end else begin
            buf_v     = 1'b1;
            buf_start = (e < act_end) ? act_end : e + 1;
            x.w = w; x.start = buf_start;
            q.push_back(x);
        end
    endtask

    // One bench cycle on the CLK_DIV=2 instance, optionally with a strobe
    task automatic cyc_drive(input bit s, input logic [8:0] w);
        @(negedge clk);
        en   = s;
        data = s ? w : 9'($urandom);
        if (s) model_strobe(cyc + 1, w);
    endtask

    // Bus monitor state
    bit         mon_prev_cs = 1'b1;
    bit         mon_prev_sclk = 1'b0;
    bit         mon_prev_mosi = 1'b0;
    logic [7:0] mon_sh = '0;
    int         mon_bits = 0;
    int         mon_start = 0;
    int         mon_first_rise = 0;
    bit         mon_dc0 = 1'b0;
    bit         mon_dc_ok = 1'b1;
    bit         mon_stable = 1'b1;
    exp_t       mx;

    // Monitor: decode frames on the bus and compare completed words to the scoreboard
    always @(negedge clk) begin
        if (rst) begin
            mon_bits = 0;
        end else begin
            if (mon_prev_cs && !cs_n) begin
                mon_start  = cyc;
                mon_dc0    = dc;
                mon_bits   = 0;
                mon_dc_ok  = 1'b1;
                mon_stable = 1'b1;
                check("busy_at_cs_fall", int'(busy), 1);
            end
            if (!cs_n && dc !== mon_dc0) mon_dc_ok = 1'b0;
            if (!mon_prev_sclk && sclk) begin
                if (mon_bits == 0) mon_first_rise = cyc;
                mon_sh = {mon_sh[6:0], mosi};
                mon_bits++;
                if (mosi !== mon_prev_mosi) mon_stable = 1'b0;
            end
            if (wr_done) begin
                n_done++;
                if (q.size() == 0) begin
                    check("unexpected_wr_done", 1, 0);
                end else begin
                    mx = q.pop_front();
                    check("cs_fall_time", mon_start, mx.start);
                    check("wr_done_time", cyc, mx.start + 17 * D);
                    check("first_rise_time", mon_first_rise, mx.start + D);
                    check("bit_count", mon_bits, 8);
                    check("byte", int'(mon_sh), int'(mx.w[7:0]));
                    check("dc", int'(mon_dc0), int'(mx.w[8]));
                    check("dc_held", int'(mon_dc_ok), 1);
                    check("mosi_stable_at_rise", int'(mon_stable), 1);
                    check("cs_high_at_done", int'(cs_n), 1);
                end
            end
        end
        mon_prev_cs   = cs_n;
        mon_prev_sclk = sclk;
        mon_prev_mosi = mosi;
    end

    initial begin : stim
        int base_done;
        int lows;
        int s;
        int toggles, rises, done_at, unstable, dc_bad;
        bit p_sclk, p_mosi;
        logic [7:0] sh;

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cs_n", int'(cs_n), 1);
        check("rst_sclk", int'(sclk), 0);
        check("rst_mosi", int'(mosi), 0);
        check("rst_dc", int'(dc), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_wr_done", int'(wr_done), 0);
        check("rst_ovf", int'(ovf), 0);
        check("rst_cs1_n", int'(cs1_n), 1);
        rst = 1'b0;

        // Single command word 0x2A
        cyc_drive(1'b1, 9'h02A);
        repeat (45) cyc_drive(1'b0, '0);

        // Pixel 0x1FF followed by buffered 0x100 five cycles later
        cyc_drive(1'b1, 9'h1FF);
        repeat (4) cyc_drive(1'b0, '0);
        cyc_drive(1'b1, 9'h100);
        repeat (80) cyc_drive(1'b0, '0);
        check("ovf_after_buffered", int'(ovf), 0);

        // Three strobes three cycles apart: third is dropped
        base_done = n_done;
        cyc_drive(1'b1, 9'h0C3);
        repeat (2) cyc_drive(1'b0, '0);
        cyc_drive(1'b1, 9'h13C);
        repeat (2) cyc_drive(1'b0, '0);
        check("ovf_before_drop", int'(ovf), 0);
        cyc_drive(1'b1, 9'h0F0);
        cyc_drive(1'b0, '0);
        check("ovf_after_drop", int'(ovf), int'(ovf_m));
        repeat (80) cyc_drive(1'b0, '0);
        check("two_done_pulses", n_done - base_done, 2);
        check("ovf_sticky", int'(ovf), 1);

        // Reset mid-transfer with a word waiting in the buffer
        cyc_drive(1'b1, 9'h1A5);
        repeat (2) cyc_drive(1'b0, '0);
        cyc_drive(1'b1, 9'h05A);
        repeat (8) cyc_drive(1'b0, '0);
        @(negedge clk);
        rst = 1'b1;
        q.delete();
        act_end = -1000; buf_v = 1'b0; ovf_m = 1'b0;
        @(negedge clk);
        check("midrst_cs_n", int'(cs_n), 1);
        check("midrst_sclk", int'(sclk), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_ovf", int'(ovf), 0);
        rst = 1'b0;
        base_done = n_done;
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            cyc_drive(1'b0, '0);
            if (!cs_n) lows++;
        end
        check("no_cs_after_rst", lows, 0);
        check("no_done_after_rst", n_done - base_done, 0);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            cyc_drive(($urandom_range(0, 11) == 0), 9'($urandom));
        end
        repeat (120) cyc_drive(1'b0, '0);
        check("scoreboard_drained", q.size(), 0);
        check("rand_ovf", int'(ovf), int'(ovf_m));
        check("rand_busy_idle", int'(busy), 0);

        // CLK_DIV=1 instance: data word 0x55
        @(negedge clk);
        en1 = 1'b1; data1 = {LCD_DC_DATA, 8'h55};
        s = cyc + 1;
        @(negedge clk);
        en1 = 1'b0; data1 = '0;
        check("d1_cs_fall", int'(cs1_n), 0);
        p_sclk = sclk1; p_mosi = mosi1;
        toggles = 0; rises = 0; done_at = -1; unstable = 0; dc_bad = 0; sh = '0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (sclk1 != p_sclk) toggles++;
            if (!p_sclk && sclk1) begin
                rises++;
                sh = {sh[6:0], mosi1};
                if (mosi1 != p_mosi) unstable++;
            end
            if (!cs1_n && dc1 != LCD_DC_DATA) dc_bad++;
            if (wd1) done_at = cyc;
            p_sclk = sclk1; p_mosi = mosi1;
        end
        check("d1_toggles", toggles, 16);
        check("d1_rises", rises, 8);
        check("d1_byte", int'(sh), 8'h55);
        check("d1_done_time", done_at, s + 17);
        check("d1_mosi_stable", unstable, 0);
        check("d1_dc", dc_bad, 0);
        check("d1_busy_idle", int'(busy1), 0);
        check("d1_ovf", int'(ovf1), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_lcd_spi_tx
